// File: rtl/mdu_sequencer.sv
// mdu_sequencer: E-stage multiply/divide unit with HI/LO ownership.
// The result is computed from A/B at the start edge and held in pending
// registers; the down-counter only models latency before the HI/LO commit.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no operation in flight; accepts start or mthi/mtlo
// S_BUSY | counting down latency; pending result committed at count 1
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  MDUOp,
    input  logic        MDUStart,
    input  logic        MDUWrite,
    input  logic        Req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D_mdu_use,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

    localparam logic [4:0] OP_MULT  = 5'd0;
    localparam logic [4:0] OP_MULTU = 5'd1;
    localparam logic [4:0] OP_DIV   = 5'd2;
    localparam logic [4:0] OP_DIVU  = 5'd3;
    localparam logic [4:0] OP_MFHI  = 5'd4;
    localparam logic [4:0] OP_MFLO  = 5'd5;
    localparam logic [4:0] OP_MTHI  = 5'd6;
    localparam logic [4:0] OP_MTLO  = 5'd7;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;
    logic               pend_wr_q, pend_wr_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic signed [31:0] dvs_s;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic [31:0]        dvs_u;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               res_wr;
    logic               start_ok;

    // Arithmetic datapath; divisor forced to 1 on zero so no X leaks, and the
    // single signed overflow case is handled explicitly.
    always_comb begin
        prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u   = {32'd0, A} * {32'd0, B};
        div_zero = (B == 32'd0);
        div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        dvs_s    = (div_zero || div_ovf) ? 32'sd1 : $signed(B);
        quo_s    = $signed(A) / dvs_s;
        rem_s    = $signed(A) % dvs_s;
        dvs_u    = div_zero ? 32'd1 : B;
        quo_u    = A / dvs_u;
        rem_u    = A % dvs_u;

        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b1;
        case (MDUOp)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                res_hi = div_ovf ? 32'd0 : rem_s;
                res_lo = div_ovf ? 32'h8000_0000 : quo_s;
                res_wr = ~div_zero;
            end
            OP_DIVU: begin
                res_hi = rem_u;
                res_lo = quo_u;
                res_wr = ~div_zero;
            end
            default: res_wr = 1'b0;
        endcase
    end

    // Sequencer next-state: start, mthi/mtlo writes and latency countdown.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        start_ok  = MDUStart && !Req && (MDUOp <= OP_DIVU);

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d   = S_BUSY;
                    cnt_d     = MDUOp[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    pend_wr_d = res_wr;
                end else if (MDUWrite && !Req) begin
                    if (MDUOp == OP_MTHI) begin
                        hi_d = A;
                    end else if (MDUOp == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            S_BUSY: begin
                // Start/write requests are ignored here; Req does not cancel.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter, pending result and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Outputs: stall covers both the in-flight op and a start sitting in E.
    always_comb begin
        Busy  = (state_q == S_BUSY);
        Stall = D_mdu_use & (Busy | (MDUStart & ~Req));
        HI    = hi_q;
        LO    = lo_q;
        case (MDUOp)
            OP_MFHI: MDUOut = hi_q;
            OP_MFLO: MDUOut = lo_q;
            default: MDUOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: latency, arithmetic corners, flush
// behaviour, divide by zero and asynchronous reset.
module tb_mdu_sequencer;

    logic        clk;
    logic        reset;
    logic [4:0]  MDUOp;
    logic        MDUStart;
    logic        MDUWrite;
    logic        Req;
    logic [31:0] A;
    logic [31:0] B;
    logic        D_mdu_use;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    int total = 0;
    int bad   = 0;
    int busy_n;
    int stall_n;

    mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .MDUOp     (MDUOp),
        .MDUStart  (MDUStart),
        .MDUWrite  (MDUWrite),
        .Req       (Req),
        .A         (A),
        .B         (B),
        .D_mdu_use (D_mdu_use),
        .Busy      (Busy),
        .Stall     (Stall),
        .HI        (HI),
        .LO        (LO),
        .MDUOut    (MDUOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one mult/div with a D-stage MDU user waiting; count Busy and Stall
    // cycles. pulse_kind 1 pulses Req, 2 injects an mtlo during busy cycle 2.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int pulse_kind, output int nbusy, output int nstall);
        int guard;
        nbusy  = 0;
        nstall = 0;
        MDUOp     = op;
        A         = a;
        B         = b;
        MDUStart  = 1'b1;
        D_mdu_use = 1'b1;
        #1;
        if (Stall) nstall++;
        step();
        MDUStart = 1'b0;
        A        = 32'd0;
        B        = 32'd0;
        guard    = 0;
        while (Busy && guard < 50) begin
            Req      = (pulse_kind == 1 && nbusy == 2);
            MDUWrite = (pulse_kind == 2 && nbusy == 2);
            MDUOp    = (pulse_kind == 2 && nbusy == 2) ? 5'd7 : op;
            A        = (pulse_kind == 2 && nbusy == 2) ? 32'hDEAD_BEEF : 32'd0;
            #1;
            if (Stall) nstall++;
            nbusy++;
            guard++;
            step();
        end
        Req       = 1'b0;
        MDUWrite  = 1'b0;
        A         = 32'd0;
        D_mdu_use = 1'b0;
        MDUOp     = 5'd31;
    endtask

    initial begin
        reset     = 1'b1;
        MDUOp     = 5'd31;
        MDUStart  = 1'b0;
        MDUWrite  = 1'b0;
        Req       = 1'b0;
        A         = 32'd0;
        B         = 32'd0;
        D_mdu_use = 1'b0;
        step();
        step();
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        reset = 1'b0;
        step();

        // signed mult -2 * 3
        run_op(5'd0, 32'hFFFF_FFFE, 32'd3, 0, busy_n, stall_n);
        chk("mult_busy_cycles", busy_n, 32'd5);
        chk("mult_stall_cycles", stall_n, 32'd6);
        chk("mult_busy_low", {31'd0, Busy}, 32'd0);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFA);
        MDUOp = 5'd5; #1;
        chk("mflo_out", MDUOut, 32'hFFFF_FFFA);
        MDUOp = 5'd4; #1;
        chk("mfhi_out", MDUOut, 32'hFFFF_FFFF);
        MDUOp = 5'd6; #1;
        chk("mdu_out_other", MDUOut, 32'd0);

        // signed div -7 / 2
        run_op(5'd2, 32'hFFFF_FFF9, 32'd2, 0, busy_n, stall_n);
        chk("div_busy_cycles", busy_n, 32'd10);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        chk("div_hi", HI, 32'hFFFF_FFFF);

        // divu and signed overflow
        run_op(5'd3, 32'hFFFF_FFFF, 32'h10, 0, busy_n, stall_n);
        chk("divu_busy_cycles", busy_n, 32'd10);
        chk("divu_lo", LO, 32'h0FFF_FFFF);
        chk("divu_hi", HI, 32'h0000_000F);
        run_op(5'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, busy_n, stall_n);
        chk("div_ovf_lo", LO, 32'h8000_0000);
        chk("div_ovf_hi", HI, 32'd0);

        // start flushed by Req
        MDUOp = 5'd0; A = 32'd5; B = 32'd5; MDUStart = 1'b1; Req = 1'b1; D_mdu_use = 1'b1;
        #1;
        chk("flush_stall", {31'd0, Stall}, 32'd0);
        step();
        MDUStart = 1'b0; Req = 1'b0; D_mdu_use = 1'b0;
        #1;
        chk("flush_busy", {31'd0, Busy}, 32'd0);
        step();
        chk("flush_busy_later", {31'd0, Busy}, 32'd0);
        chk("flush_hi", HI, 32'd0);
        chk("flush_lo", LO, 32'h8000_0000);

        // mthi flushed, then accepted
        MDUOp = 5'd6; A = 32'h1234; MDUWrite = 1'b1; Req = 1'b1;
        step();
        chk("mthi_flush_hi", HI, 32'd0);
        Req = 1'b0;
        step();
        MDUWrite = 1'b0;
        chk("mthi_hi", HI, 32'h1234);

        // unsupported op with MDUStart is a no-op
        MDUOp = 5'd9; MDUStart = 1'b1;
        step();
        MDUStart = 1'b0;
        chk("bad_op_busy", {31'd0, Busy}, 32'd0);

        // Req during busy does not cancel multu 0x10000 * 0x10000
        run_op(5'd1, 32'h0001_0000, 32'h0001_0000, 1, busy_n, stall_n);
        chk("req_busy_cycles", busy_n, 32'd5);
        chk("req_busy_hi", HI, 32'd1);
        chk("req_busy_lo", LO, 32'd0);

        // mtlo while busy is ignored; result latched at start survives
        run_op(5'd0, 32'd7, 32'd6, 2, busy_n, stall_n);
        chk("wr_busy_cycles", busy_n, 32'd5);
        chk("wr_busy_lo", LO, 32'd42);
        chk("wr_busy_hi", HI, 32'd0);

        // divide by zero keeps HI/LO
        MDUWrite = 1'b1; MDUOp = 5'd6; A = 32'h11;
        step();
        MDUOp = 5'd7; A = 32'h22;
        step();
        MDUWrite = 1'b0;
        run_op(5'd2, 32'd7, 32'd0, 0, busy_n, stall_n);
        chk("div0_busy_cycles", busy_n, 32'd10);
        chk("div0_hi", HI, 32'h11);
        chk("div0_lo", LO, 32'h22);
        MDUWrite = 1'b1; MDUOp = 5'd7; A = 32'hABCD;
        step();
        MDUWrite = 1'b0; MDUOp = 5'd5;
        #1;
        chk("mtlo_lo", LO, 32'hABCD);
        chk("mtlo_mflo", MDUOut, 32'hABCD);

        // reset mid-operation
        MDUOp = 5'd2; A = 32'd100; B = 32'd3; MDUStart = 1'b1;
        step();
        MDUStart = 1'b0;
        step();
        step();
        chk("pre_reset_busy", {31'd0, Busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
        chk("rst_mid_hi", HI, 32'd0);
        chk("rst_mid_lo", LO, 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) step();
        MDUOp = 5'd5;
        #1;
        chk("rst_mid_mflo", MDUOut, 32'd0);
        chk("rst_mid_busy_later", {31'd0, Busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multiply/divide unit with its own sequencer for the P7 pipeline.
- Sits in the E stage: it accepts MDU operations decoded by the controller, models multi-cycle mult/div latency, and owns the HI/LO registers.
- Generates the D-stage stall request for any MDU-using instruction while an operation is pending.
- Honours the exception/interrupt request so that a flushed E-stage instruction never modifies HI/LO.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
MDUOp  input  5  E-stage op: 0 mult, 1 multu, 2 div, 3 divu, 4 mfhi, 5 mflo, 6 mthi, 7 mtlo; other codes = no-op
MDUStart  input  1  E-stage instruction is mult/multu/div/divu
MDUWrite  input  1  E-stage instruction is mthi/mtlo
Req  input  1  exception/interrupt flush this cycle; suppresses E-stage start/write
A  input  32  forwarded rs value
B  input  32  forwarded rt value
D_mdu_use  input  1  D-stage instruction is mcal, mf or mt
Busy  output  1  operation in flight
Stall  output  1  D-stage stall request
HI  output  32  HI register
LO  output  32  LO register
MDUOut  output  32  mfhi -> HI, mflo -> LO, else 0 (combinational)

Behaviour:
- Reset (async, immediate): HI=0, LO=0, Busy=0, counter=0, pending results=0, state IDLE. Reset mid-operation discards the operation; HI/LO stay 0.
- States: IDLE, BUSY.
- IDLE to BUSY: on a clock edge with MDUStart=1, Req=0, op in 0..3.
  - Compute the result from A/B at that edge and latch it into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
- BUSY, each edge: decrement counter. When counter==1 at the edge, commit pending values to HI/LO, counter becomes 0, return to IDLE.
- Busy = (state==BUSY). Busy rises the cycle after the start edge and stays high exactly N cycles (N = latency parameter). HI/LO show new values on the first cycle Busy is low again.
- Stall = D_mdu_use & (Busy | (MDUStart & ~Req)). Combinational, no registered delay.
- Arithmetic:
  - mult: signed 32x32 to 64; HI = bits [63:32], LO = bits [31:0].
  - multu: same, unsigned.
  - div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
  - Divisor 0 (div/divu): full latency and Busy are still observed; HI/LO are left unchanged at commit.
- mthi/mtlo: when MDUWrite=1, Req=0 and state IDLE, write A into HI or LO at the edge (zero latency, no Busy).
- MDUStart or MDUWrite while Busy: ignored, no state change. The pipeline guarantees this never happens via Stall; the block must still be safe.
- Req=1 with MDUStart or MDUWrite in the same cycle: the operation is dropped, no Busy, HI/LO unchanged.
- Req during BUSY: does not cancel. The in-flight op belongs to an older committed instruction and completes normally.
- mfhi/mflo during Busy cannot reach E (stalled in D). MDUOut reads current HI/LO combinationally regardless of Busy.
- Simultaneous commit edge and new start: impossible, because Stall holds the next MDU instruction in D while Busy is high. The first new start is possible the cycle Busy is low.
- MDUOp codes 8..31 with MDUStart=1: treated as no-op, state stays IDLE.

Test Plan:
- Reset mid-op: start div, assert reset at busy cycle 3 -> Busy=0, HI=0, LO=0 immediately; a later mflo returns 0.
- Signed mult: MDUOp=0, A=0xFFFFFFFE (-2), B=3 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. A D-stage mflo issued the same cycle sees Stall=1 for 6 cycles (start cycle + 5 busy).
- Signed div corner: MDUOp=2, A=-7 (0xFFFFFFF9), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu and overflow: MDUOp=3, A=0xFFFFFFFF, B=0x10 -> LO=0x0FFFFFFF, HI=0xF. Then MDUOp=2, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Flush/no-cancel:
  - MDUStart=1 with Req=1 -> Busy stays 0, HI/LO unchanged.
  - mthi A=0x1234 with Req=1 -> HI unchanged; with Req=0 -> HI=0x1234 the next cycle.
  - Req pulsed during BUSY -> op still commits on schedule.
- Divide by zero and mtlo: HI=0x11, LO=0x22, then div by 0 -> Busy 10 cycles, HI/LO stay 0x11/0x22. Then mtlo A=0xABCD -> LO=0xABCD, MDUOut with mflo = 0xABCD.
